// File: rtl/i2c_txn_queue.sv
// i2c_txn_queue: buffers host I2C transaction requests, launches them one at a
// time on the controller interface, and returns one in-order status response
// per request. A watchdog bounds how long a launched transaction may stay open.
module i2c_txn_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [7:0]  cmd_address,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_bytesend,
  output logic        init_transaction,
  output logic        rw,
  output logic [7:0]  address,
  output logic [31:0] data,
  output logic [3:0]  bytesend,
  input  logic        ctrl_done,
  input  logic        ctrl_nack,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_nack,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [7:0]  address;
    logic [31:0] data;
    logic [3:0]  bytesend;
  } req_t;

  state_t          state_q, state_d;
  req_t            mem [DEPTH];
  req_t            wr_entry;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wdog;
  logic            push, pop, wd_expired;

  assign cmd_ready  = (count != FULL);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == S_IDLE) && (count != '0);
  assign wd_expired = (wdog == WD_LAST);

  assign wr_entry.rw       = cmd_rw;
  assign wr_entry.address  = cmd_address;
  assign wr_entry.data     = cmd_data;
  assign wr_entry.bytesend = (cmd_bytesend > 4'd4) ? 4'd4 : cmd_bytesend;

  // FIFO storage: write the clamped request at the tail
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a done on the expiry cycle still takes the done path
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (count != '0) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (ctrl_done || wd_expired) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    init_transaction = (state_q == S_LAUNCH);
    rsp_valid        = (state_q == S_RESP);
    busy             = (state_q != S_IDLE) || (count != '0);
  end

  // Controller-facing request registers, loaded only on pop so they stay stable until the next launch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rw       <= 1'b0;
      address  <= '0;
      data     <= '0;
      bytesend <= '0;
    end else if (pop) begin
      rw       <= mem[rd_ptr].rw;
      address  <= mem[rd_ptr].address;
      data     <= mem[rd_ptr].data;
      bytesend <= mem[rd_ptr].bytesend;
    end
  end

  // Watchdog and response status capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog        <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state_q == S_LAUNCH) begin
        wdog <= '0;
      end else if (state_q == S_WAIT) begin
        if (ctrl_done) begin
          rsp_nack    <= ctrl_nack;
          rsp_timeout <= 1'b0;
        end else if (wd_expired) begin
          rsp_nack    <= 1'b0;
          rsp_timeout <= 1'b1;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_queue.sv
// Self-checking bench for i2c_txn_queue with a queue-based reference model.
module tb_i2c_txn_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;
  localparam int unsigned NREQ  = DEPTH + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [7:0]  cmd_address;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_bytesend;
  logic        init_transaction, rw;
  logic [7:0]  address;
  logic [31:0] data;
  logic [3:0]  bytesend;
  logic        ctrl_done, ctrl_nack;
  logic        rsp_valid, rsp_ready, rsp_nack, rsp_timeout, busy;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  i2c_txn_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_bytesend(cmd_bytesend),
    .init_transaction(init_transaction), .rw(rw), .address(address),
    .data(data), .bytesend(bytesend),
    .ctrl_done(ctrl_done), .ctrl_nack(ctrl_nack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_nack(rsp_nack),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Request as seen by the controller: {rw, address, data, bytesend} with bytesend capped at 4
  function automatic logic [44:0] expect_req(input logic r, input logic [7:0] a,
                                             input logic [31:0] d, input logic [3:0] b);
    int unsigned nb;
    nb = (b > 4) ? 4 : b;
    return {r, a, d, 4'(nb)};
  endfunction

  task automatic push_req(input logic r, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] b);
    cmd_rw = r; cmd_address = a; cmd_data = d; cmd_bytesend = b;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !cmd_ready; k++) tick();
    tick();
    cmd_valid = 1'b0;
  endtask

  // Close out a launched transaction with a done pulse and immediate consumption
  task automatic finish_txn;
    tick();
    ctrl_done = 1'b1; ctrl_nack = 1'b0;
    tick();
    ctrl_done = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({init_transaction, rw, address, data, bytesend, rsp_valid, rsp_nack, rsp_timeout, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got init=%b rw=%b addr=%h data=%h bs=%h rv=%b rn=%b rt=%b busy=%b expected all 0",
               init_transaction, rw, address, data, bytesend, rsp_valid, rsp_nack, rsp_timeout, busy);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single_write;
    cmd_rw = 1'b1; cmd_address = 8'hA0; cmd_data = 32'hDEADBEEF; cmd_bytesend = 4'd4;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (init_transaction !== 1'b0) begin
      n_fail++; $display("FAIL single_early_init: got %b expected 0", init_transaction);
    end
    tick();
    n_cmp++;
    if ({init_transaction, rw, address, data, bytesend} !== {1'b1, expect_req(1'b1, 8'hA0, 32'hDEADBEEF, 4'd4)}) begin
      n_fail++;
      $display("FAIL single_launch: got init=%b rw=%b addr=%h data=%h bs=%0d expected 1 1 a0 deadbeef 4",
               init_transaction, rw, address, data, bytesend);
    end
    tick();
    n_cmp++;
    if (init_transaction !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse_width: got %b expected 0", init_transaction);
    end
    ctrl_done = 1'b1; ctrl_nack = 1'b0;
    tick();
    ctrl_done = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_nack, rsp_timeout} !== 3'b100) begin
      n_fail++; $display("FAIL single_response: got %b%b%b expected 100", rsp_valid, rsp_nack, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_consume: got rv=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_fill_order;
    logic [44:0] reqs [NREQ];
    logic [44:0] launch_q [$];
    logic [1:0]  exp_rsp [$];
    logic [44:0] cur;
    logic [1:0]  er;
    int unsigned accepted = 0, launched = 0, answered = 0, done_cd = 0;
    bit agent_on = 1'b0, in_flight = 1'b0, accept, consume;
    for (int i = 0; i < int'(NREQ); i++)
      reqs[i] = {1'($urandom), 8'($urandom), 32'($urandom), 4'($urandom_range(0, 15))};
    cur = '0;
    {cmd_rw, cmd_address, cmd_data, cmd_bytesend} = reqs[0];
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 8) begin
        n_cmp++;
        if (accepted != DEPTH + 1 || cmd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_stall: got accepted=%0d ready=%b expected %0d 0", accepted, cmd_ready, DEPTH + 1);
        end
        agent_on = 1'b1;
      end
      accept = cmd_valid && cmd_ready;
      if (agent_on && done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) begin
          ctrl_done = 1'b1;
          ctrl_nack = 1'($urandom);
          exp_rsp.push_back({ctrl_nack, 1'b0});
        end
      end
      rsp_ready = 1'($urandom);
      consume = rsp_valid && rsp_ready;
      if (consume) begin
        n_cmp++;
        er = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 2'bxx;
        if ({rsp_nack, rsp_timeout} !== er) begin
          n_fail++; $display("FAIL fill_response: got %b%b expected %b", rsp_nack, rsp_timeout, er);
        end
        answered++;
        in_flight = 1'b0;
      end
      tick();
      ctrl_done = 1'b0;
      if (accept) begin
        launch_q.push_back(expect_req(reqs[accepted][44], reqs[accepted][43:36],
                                      reqs[accepted][35:4], reqs[accepted][3:0]));
        accepted++;
        if (accepted < NREQ) {cmd_rw, cmd_address, cmd_data, cmd_bytesend} = reqs[accepted];
        else cmd_valid = 1'b0;
      end
      if (init_transaction) begin
        launched++;
        n_cmp++;
        if (in_flight) begin
          n_fail++; $display("FAIL fill_overlap: launch %0d while response outstanding", launched);
        end
        cur = (launch_q.size() > 0) ? launch_q.pop_front() : 'x;
        n_cmp++;
        if ({rw, address, data, bytesend} !== cur) begin
          n_fail++; $display("FAIL fill_launch: got %h expected %h", {rw, address, data, bytesend}, cur);
        end
        in_flight = 1'b1;
        done_cd = $urandom_range(2, 4);
      end else if (in_flight) begin
        n_cmp++;
        if ({rw, address, data, bytesend} !== cur) begin
          n_fail++; $display("FAIL fill_stable: got %h expected %h", {rw, address, data, bytesend}, cur);
        end
      end
      if (answered == NREQ) break;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    n_cmp++;
    if (answered != NREQ || launched != NREQ || accepted != NREQ) begin
      n_fail++;
      $display("FAIL fill_counts: got acc=%0d launch=%0d rsp=%0d expected %0d each", accepted, launched, answered, NREQ);
    end
  endtask

  task automatic test_timeout;
    int unsigned k;
    bit extra_init = 1'b0;
    push_req(1'b0, 8'h31, 32'h1111_2222, 4'd2);
    push_req(1'b1, 8'h42, 32'h3333_4444, 4'd3);
    for (int j = 0; j < 10 && !init_transaction; j++) tick();
    n_cmp++;
    if (init_transaction !== 1'b1 || address !== 8'h31) begin
      n_fail++; $display("FAIL to_first_launch: got init=%b addr=%h expected 1 31", init_transaction, address);
    end
    tick();
    for (k = 1; k <= 40; k++) begin
      tick();
      if (rsp_valid) break;
    end
    n_cmp++;
    if (k != TO || {rsp_valid, rsp_nack, rsp_timeout} !== 3'b101) begin
      n_fail++;
      $display("FAIL to_latency: got cycles=%0d rsp=%b%b%b expected %0d 101", k, rsp_valid, rsp_nack, rsp_timeout, TO);
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      if (init_transaction || !rsp_valid) extra_init = 1'b1;
    end
    n_cmp++;
    if (extra_init) begin
      n_fail++; $display("FAIL to_hold: got launch or dropped response before rsp_ready expected none");
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, init_transaction} !== 2'b00) begin
      n_fail++; $display("FAIL to_consume: got rv=%b init=%b expected 0 0", rsp_valid, init_transaction);
    end
    tick();
    n_cmp++;
    if ({init_transaction, rw, address, data, bytesend} !== {1'b1, expect_req(1'b1, 8'h42, 32'h3333_4444, 4'd3)}) begin
      n_fail++;
      $display("FAIL to_second_launch: got init=%b req=%h expected 1 %h", init_transaction,
               {rw, address, data, bytesend}, expect_req(1'b1, 8'h42, 32'h3333_4444, 4'd3));
    end
    finish_txn();
  endtask

  task automatic test_done_vs_timeout;
    push_req(1'($urandom), 8'($urandom), 32'($urandom), 4'd1);
    for (int j = 0; j < 10 && !init_transaction; j++) tick();
    tick();
    for (int j = 0; j < int'(TO) - 1; j++) tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL race_early: got rsp_valid=%b expected 0", rsp_valid);
    end
    ctrl_done = 1'b1; ctrl_nack = 1'b1;
    tick();
    ctrl_done = 1'b0; ctrl_nack = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_nack, rsp_timeout} !== 3'b110) begin
      n_fail++; $display("FAIL race_done_wins: got %b%b%b expected 110", rsp_valid, rsp_nack, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_clamp_hold;
    logic n;
    n = 1'($urandom);
    push_req(1'b0, 8'h55, 32'hA5A5_0001, 4'd9);
    push_req(1'b0, 8'h66, 32'hA5A5_0002, 4'd0);
    for (int j = 0; j < 10 && !init_transaction; j++) tick();
    n_cmp++;
    if (init_transaction !== 1'b1 || bytesend !== 4'd4) begin
      n_fail++; $display("FAIL clamp_high: got init=%b bs=%0d expected 1 4", init_transaction, bytesend);
    end
    tick();
    ctrl_done = 1'b1; ctrl_nack = n;
    tick();
    ctrl_done = 1'b0; ctrl_nack = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_nack, rsp_timeout, init_transaction, bytesend} !== {1'b1, n, 1'b0, 1'b0, 4'd4}) begin
        n_fail++;
        $display("FAIL hold_stable: got rv=%b rn=%b rt=%b init=%b bs=%0d expected 1 %b 0 0 4",
                 rsp_valid, rsp_nack, rsp_timeout, init_transaction, bytesend, n);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    n_cmp++;
    if (init_transaction !== 1'b1 || bytesend !== 4'd0 || address !== 8'h66) begin
      n_fail++; $display("FAIL clamp_zero: got init=%b bs=%0d addr=%h expected 1 0 66", init_transaction, bytesend, address);
    end
    finish_txn();
  endtask

  task automatic test_reset_mid;
    bit stale = 1'b0;
    push_req(1'b1, 8'h10, 32'h0000_0010, 4'd1);
    push_req(1'b1, 8'h20, 32'h0000_0020, 4'd2);
    push_req(1'b1, 8'h30, 32'h0000_0030, 4'd3);
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b1 || address !== 8'h10) begin
      n_fail++; $display("FAIL mid_setup: got busy=%b addr=%h expected 1 10", busy, address);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({init_transaction, rw, address, data, bytesend, rsp_valid, rsp_nack, rsp_timeout, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rw=%b addr=%h data=%h bs=%h rv=%b busy=%b expected all 0",
               rw, address, data, bytesend, rsp_valid, busy);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_fail++; $display("FAIL mid_release: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
    for (int j = 0; j < 20; j++) begin
      ctrl_done = 1'($urandom); ctrl_nack = 1'($urandom);
      tick();
      if (init_transaction || rsp_valid || busy) stale = 1'b1;
    end
    ctrl_done = 1'b0; ctrl_nack = 1'b0;
    n_cmp++;
    if (stale) begin
      n_fail++; $display("FAIL mid_stale: got activity after reset expected none");
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_address = '0; cmd_data = '0; cmd_bytesend = '0;
    ctrl_done = 1'b0; ctrl_nack = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_single_write();
    test_fill_order();
    test_timeout();
    test_done_vs_timeout();
    test_clamp_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_txn_queue.md
Name: i2c_txn_queue

Overview:
- Upstream command stage for the I2C controller. Buffers host transaction requests (rw, address, up to 4 data bytes, byte count) in a small FIFO.
- Launches one request at a time on the controller's init_transaction/rw/address/data/bytesend inputs and holds them stable until the controller reports completion or a watchdog expires.
- Returns one in-order status response per request.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 65535, clock cycles in WAIT before the transaction is declared hung.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host request present
- cmd_ready  out  1  queue can accept a request
- cmd_rw  in  1  1 = write, 0 = read
- cmd_address  in  8  target address byte
- cmd_data  in  32  write payload, MSB byte sent first
- cmd_bytesend  in  4  data byte count
- init_transaction  out  1  single-cycle launch pulse to the controller
- rw  out  1  to controller
- address  out  8  to controller
- data  out  32  to controller
- bytesend  out  4  to controller
- ctrl_done  in  1  controller finished the current transaction (pulse)
- ctrl_nack  in  1  sampled with ctrl_done; 1 = slave NACKed
- rsp_valid  out  1  response available
- rsp_ready  in  1  host consumes response
- rsp_nack  out  1  response: NACK seen
- rsp_timeout  out  1  response: watchdog expired
- busy  out  1  state is not IDLE or FIFO is not empty

Behaviour:
- Reset (async, immediate):
  - FIFO is emptied and state goes to IDLE.
  - Outputs: init_transaction=0, rw=0, address=0, data=0, bytesend=0, rsp_valid=0, rsp_nack=0, rsp_timeout=0, busy=0.
  - cmd_ready=1 from the first edge after reset deasserts.
  - A reset mid-transaction discards the in-flight request and all queued requests; no response is issued.
- FIFO:
  - A push occurs on a clock edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready = (count != DEPTH) and is registered-count based, with no combinational path from cmd_valid.
  - Pointers wrap modulo DEPTH.
  - Push and pop on the same edge leaves count unchanged. When count==DEPTH, no push is possible, even if a pop happens that edge.
- bytesend clamp: a stored bytesend value greater than 4 is clamped to 4 on push. A value of 0 is legal (address-only probe) and is forwarded unchanged.
- State machine:
  - IDLE: if FIFO not empty, pop the head into the output registers (rw/address/data/bytesend), set init_transaction=1, and go to LAUNCH.
  - LAUNCH: init_transaction=0, clear the watchdog, go to WAIT. init_transaction is high for exactly one cycle.
  - WAIT:
    - If ctrl_done: latch rsp_nack=ctrl_nack, rsp_timeout=0, rsp_valid=1, go to RESP.
    - Else if watchdog == TIMEOUT_CYCLES-1: rsp_nack=0, rsp_timeout=1, rsp_valid=1, go to RESP.
    - Else increment the watchdog.
    - If ctrl_done arrives on the same cycle the watchdog expires, done wins.
  - RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_ready, clear rsp_valid and go to IDLE.
- Output stability: rw/address/data/bytesend are held constant from the launch edge until the next pop. They never change in LAUNCH, WAIT or RESP.
- ctrl_done/ctrl_nack are ignored outside WAIT.
- Latency:
  - A request pushed into an empty queue on edge E, with state IDLE: the pop and init_transaction rise occur on edge E+1.
  - Minimum spacing between consecutive launches is 4 cycles: LAUNCH, WAIT (done), RESP (immediate rsp_ready), IDLE.
- Ordering: strictly in order. The next request is never launched until the previous response has been consumed.
- busy=1 whenever state != IDLE or count != 0.

Test Plan:
- Reset, push one write {rw=1, addr=0xA0, data=0xDEADBEEF, bytesend=4} into an empty queue -> init_transaction high for exactly one cycle one edge later, with address=0xA0 and data=0xDEADBEEF. Pulse ctrl_done with ctrl_nack=0 -> rsp_valid=1, rsp_nack=0, rsp_timeout=0.
- Hold cmd_valid=1 with DEPTH+2 distinct requests, controller stalled -> cmd_ready drops after DEPTH+1 accepted (DEPTH queued + 1 in flight). Responses come back in push order, one per request, with no drops or duplicates.
- With TIMEOUT_CYCLES=16, never assert ctrl_done -> rsp_timeout=1 exactly 16 cycles after entering WAIT. The next queued request launches only after rsp_ready.
- ctrl_done=1, ctrl_nack=1 on the same cycle the watchdog expires -> rsp_nack=1, rsp_timeout=0.
- Push bytesend=9, then bytesend=0 -> controller sees bytesend=4, then 0. Hold rsp_ready=0 for 10 cycles -> rsp_* stable and no second init_transaction.
- Assert reset while in WAIT with 2 requests queued -> all outputs 0 immediately, busy=0, cmd_ready=1 after release, and no stale response appears.
